vec_pair_buffer: RTL and testbench
==================================

Name: vec_pair_buffer

Overview:
- Sits directly downstream of the popcount stage (cnt1).
- Consumes its delayed sub-vector stream, valid, running weight and new-count strobe.
- Reassembles SUB_VECTOR_NO bus words into one full fingerprint vector and pairs it with its weight (|A|).
- Queues {weight, vector} pairs in a small FIFO with ready/valid output toward the Tanimoto compare stage.

Parameters:
VECTOR_WIDTH, 920, fingerprint width in bits
BUS_WIDTH, 512, input sub-vector width
SUB_VECTOR_NO, 2, bus words per vector; SUB_VECTOR_NO*BUS_WIDTH >= VECTOR_WIDTH
CNT_WIDTH, $clog2(VECTOR_WIDTH), weight width
FIFO_DEPTH, 4, output entries, power of two, >= 2

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_SubVector  in  BUS_WIDTH  delayed sub-vector from the popcount stage
i_Valid  in  1  sub-vector valid
i_Cnt  in  CNT_WIDTH  accumulator value from the popcount stage
i_CntNew  in  1  marks the last word of a vector; qualified by i_Valid
o_Vector  out  VECTOR_WIDTH  head-of-FIFO full vector
o_Weight  out  CNT_WIDTH  head-of-FIFO weight
o_Valid  out  1  FIFO non-empty
i_Ready  in  1  consumer accepts the head entry when o_Valid & i_Ready
o_Overflow  out  1  sticky, set when a completed pair is dropped

Behaviour:
- Interface: one clock, clk. Reset rstn is synchronous and active-low.
- Reset values:
  - Word counter 0; pending flag 0; FIFO empty.
  - o_Valid = 0; o_Overflow = 0.
  - o_Vector and o_Weight are don't-care while o_Valid = 0. Drive them from the storage array; no reset is needed on the array.
- Assembly:
  - Word counter r_WordIdx, width $clog2(SUB_VECTOR_NO)+1.
  - On i_Valid, i_SubVector is written to slice r_WordIdx of a SUB_VECTOR_NO*BUS_WIDTH assembly register. Word 0 is the LSBs.
  - The counter increments on i_Valid.
  - It resets to 0 on i_Valid & i_CntNew, or when it reaches SUB_VECTOR_NO-1 on a valid beat (wrap).
  - o_Vector is the lower VECTOR_WIDTH bits of the assembly; padding bits are discarded.
- Weight capture:
  - The upstream accumulator holds the full weight one cycle after the last-word strobe.
  - On i_Valid & i_CntNew at cycle t, set r_Pending.
  - At cycle t+1, i_Cnt is captured together with the assembled vector and pushed into the FIFO. r_Pending then clears.
  - i_CntNew without i_Valid is ignored.
- Snapshot: the vector is snapshotted into the FIFO at the push edge. Beats of the next vector that arrive at t+1 are written to the assembly in the same cycle. Because of this, word 0 of the next vector must not overwrite data before the push. Implement this with a separate snapshot register loaded at t, or push {vector from t, i_Cnt at t+1}. The snapshot register is the required method.
- Latency: last word valid at cycle t gives o_Valid = 1 at t+2 when the FIFO is empty. Throughput is one vector per SUB_VECTOR_NO cycles, with no bubbles required.
- FIFO:
  - Read/write pointers of $clog2(FIFO_DEPTH)+1 bits; full/empty are derived from the pointers.
  - Push while full, with no simultaneous pop: the entry is dropped, o_Overflow is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are performed and nothing is dropped.
  - Push and pop in the same cycle while empty: no bypass; the new entry appears the next cycle.
  - There is no upstream backpressure; upstream is free-running.
- Reset mid-operation: a partial vector is discarded, a pending push is cancelled, and the FIFO is flushed.

Optional Feature:
- Macro VEC_PAIR_ALIGN_CHECK_EN.
- When defined:
  - Adds output o_AlignErr (1 bit, sticky, reset 0).
  - It is set if i_Valid & i_CntNew arrives while r_WordIdx != SUB_VECTOR_NO-1.
  - It is also set if r_WordIdx wraps on a valid beat without i_CntNew.
  - The offending pair is still pushed.
- When undefined: the port is absent and no check logic is generated.

Decomposition:
- Shared package/header holds:
  - Default widths (VECTOR_WIDTH, BUS_WIDTH, SUB_VECTOR_NO).
  - CNT_WIDTH derivation.
  - A pair-entry width constant (CNT_WIDTH+VECTOR_WIDTH).
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty). The top block holds assembly, capture and overflow logic.

Test Plan:
- Single vector, BUS_WIDTH = 512, SUB_VECTOR_NO = 2:
  - Stimulus: words 0x..A5, 0x..5A back-to-back, CntNew on word 1, i_Cnt = 460 the next cycle.
  - Required: o_Valid at t+2, o_Weight = 460, o_Vector = {word1[407:0], word0}.
- Back-to-back vectors with i_Ready = 1:
  - Stimulus: 8 vectors streamed continuously.
  - Required: 8 outputs in order, weights match, no overflow.
- Backpressure:
  - Stimulus: i_Ready = 0 while 5 vectors complete, FIFO_DEPTH = 4.
  - Required: 4 entries held, o_Overflow = 1, 5th dropped. Releasing i_Ready then yields vectors 1-4.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full and i_Ready = 1 in the push cycle.
  - Required: no overflow, order preserved.
- Reset mid-vector:
  - Stimulus: rstn low after word 0, then a full vector.
  - Required: only the post-reset vector appears; o_Valid = 0 during reset.
- VEC_PAIR_ALIGN_CHECK_EN:
  - Stimulus: CntNew on word 0.
  - Required: o_AlignErr = 1 next cycle and stays set until reset.

Source files
------------

// File: rtl/vec_pair_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_pair_buffer_pkg
// Description : Default widths and pair-entry sizing for vec_pair_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pair_buffer_pkg;

    localparam int c_VECTOR_WIDTH  = 920;
    localparam int c_BUS_WIDTH     = 512;
    localparam int c_SUB_VECTOR_NO = 2;
    localparam int c_CNT_WIDTH     = $clog2(c_VECTOR_WIDTH);

    // FIFO entry is {weight, vector}
    function automatic int pair_width(input int cnt_width, input int vector_width);
        return cnt_width + vector_width;
    endfunction

    localparam int c_PAIR_WIDTH = pair_width(c_CNT_WIDTH, c_VECTOR_WIDTH);

endpackage
`default_nettype wire

// File: rtl/vec_pair_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vec_pair_buffer_sync_fifo
// Description : Single-clock FIFO, extra-MSB pointers, push-when-full dropped
//               unless a pop happens in the same cycle. No read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_pair_buffer_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/vec_pair_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vec_pair_buffer
// Description : Reassembles bus words into fingerprint vectors, pairs each
//               with its popcount weight and queues pairs toward the compare
//               stage. Optional macro VEC_PAIR_ALIGN_CHECK_EN adds o_AlignErr.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_pair_buffer
    import vec_pair_buffer_pkg::*;
#(
    parameter int VECTOR_WIDTH  = c_VECTOR_WIDTH,
    parameter int BUS_WIDTH     = c_BUS_WIDTH,
    parameter int SUB_VECTOR_NO = c_SUB_VECTOR_NO,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BUS_WIDTH-1:0]    i_SubVector,
    input  logic                    i_Valid,
    input  logic [CNT_WIDTH-1:0]    i_Cnt,
    input  logic                    i_CntNew,
    output logic [VECTOR_WIDTH-1:0] o_Vector,
    output logic [CNT_WIDTH-1:0]    o_Weight,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic                    o_Overflow
`ifdef VEC_PAIR_ALIGN_CHECK_EN
    ,
    output logic                    o_AlignErr
`endif
);

    localparam int c_ASM_WIDTH = SUB_VECTOR_NO * BUS_WIDTH;
    localparam int c_IDX_W     = $clog2(SUB_VECTOR_NO) + 1;
    localparam int c_PAIR_W    = pair_width(CNT_WIDTH, VECTOR_WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(SUB_VECTOR_NO - 1);

    logic [c_IDX_W-1:0]      r_WordIdx;
    logic [c_ASM_WIDTH-1:0]  r_Assembly;
    logic [c_ASM_WIDTH-1:0]  w_AsmNext;
    logic [VECTOR_WIDTH-1:0] r_Snapshot;
    logic                    r_Pending;
    logic                    r_Overflow;
    logic                    w_LastBeat;
    logic                    w_AtLast;
    logic                    w_Pop;
    logic                    w_Full;
    logic                    w_Empty;
    logic [c_PAIR_W-1:0]     w_FifoOut;

    assign w_LastBeat = i_Valid && i_CntNew;
    assign w_AtLast   = (r_WordIdx == c_LAST_IDX);
    assign w_Pop      = o_Valid && i_Ready;

    // Assembly including the current beat, so the snapshot sees the last word
    always_comb begin
        w_AsmNext = r_Assembly;
        if (i_Valid) begin
            w_AsmNext[32'(r_WordIdx) * BUS_WIDTH +: BUS_WIDTH] = i_SubVector;
        end
    end

    always_ff @(posedge clk) begin
        r_Assembly <= w_AsmNext;
        if (w_LastBeat) r_Snapshot <= w_AsmNext[VECTOR_WIDTH-1:0];
    end

    // Weight lags the last-word strobe by one cycle, hence the pending flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_WordIdx  <= '0;
            r_Pending  <= 1'b0;
            r_Overflow <= 1'b0;
        end else begin
            if (i_Valid) begin
                if (i_CntNew || w_AtLast) r_WordIdx <= '0;
                else                      r_WordIdx <= r_WordIdx + c_IDX_W'(1);
            end
            r_Pending <= w_LastBeat;
            if (r_Pending && w_Full && !w_Pop) r_Overflow <= 1'b1;
        end
    end

    vec_pair_buffer_sync_fifo #(
        .WIDTH (c_PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_Pending),
        .i_data  ({i_Cnt, r_Snapshot}),
        .i_pop   (w_Pop),
        .o_data  (w_FifoOut),
        .o_full  (w_Full),
        .o_empty (w_Empty)
    );

    assign o_Valid    = !w_Empty;
    assign o_Weight   = w_FifoOut[c_PAIR_W-1 -: CNT_WIDTH];
    assign o_Vector   = w_FifoOut[VECTOR_WIDTH-1:0];
    assign o_Overflow = r_Overflow;

`ifdef VEC_PAIR_ALIGN_CHECK_EN
    logic r_AlignErr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_AlignErr <= 1'b0;
        end else if ((w_LastBeat && !w_AtLast) || (i_Valid && w_AtLast && !i_CntNew)) begin
            r_AlignErr <= 1'b1;
        end
    end

    assign o_AlignErr = r_AlignErr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_pair_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_pair_buffer
// Description : Self-checking bench for vec_pair_buffer with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_pair_buffer;

    localparam int VW    = 920;
    localparam int BW    = 512;
    localparam int CW    = 10;
    localparam int AW    = 2 * BW;
    localparam int PW    = CW + VW;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rstn;
    logic [BW-1:0] i_SubVector;
    logic          i_Valid;
    logic [CW-1:0] i_Cnt;
    logic          i_CntNew;
    logic [VW-1:0] o_Vector;
    logic [CW-1:0] o_Weight;
    logic          o_Valid;
    logic          i_Ready;
    logic          o_Overflow;
`ifdef VEC_PAIR_ALIGN_CHECK_EN
    logic          o_AlignErr;
    logic          m_align;
`endif

    vec_pair_buffer dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_SubVector (i_SubVector),
        .i_Valid     (i_Valid),
        .i_Cnt       (i_Cnt),
        .i_CntNew    (i_CntNew),
        .o_Vector    (o_Vector),
        .o_Weight    (o_Weight),
        .o_Valid     (o_Valid),
        .i_Ready     (i_Ready),
        .o_Overflow  (o_Overflow)
`ifdef VEC_PAIR_ALIGN_CHECK_EN
        ,
        .o_AlignErr  (o_AlignErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests;
    int            n_fail;
    logic          ready;
    bit            rand_ready;
    logic [PW-1:0] m_q[$];
    bit            m_ovf;
    bit            m_pending;
    logic [VW-1:0] m_next_v;
    logic [VW-1:0] m_pend_v;
    logic [CW-1:0] m_next_w;
    logic [CW-1:0] m_pend_w;
    logic [BW-1:0] m_last_w1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        logic [VW-1:0] d;
        d = got ^ exp;
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: %0d bits differ, got low %h expected low %h",
                   tag, $countones(d), got[63:0], exp[63:0]);
        end
    endtask

    task automatic check_outputs();
        logic [PW-1:0] head;
        chk("valid", 64'(o_Valid), 64'(m_q.size() != 0));
        chk("overflow", 64'(o_Overflow), 64'(m_ovf));
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("weight", 64'(o_Weight), 64'(head[PW-1 -: CW]));
            chk_vec("vector", o_Vector, head[VW-1:0]);
        end
`ifdef VEC_PAIR_ALIGN_CHECK_EN
        chk("align_err", 64'(o_AlignErr), 64'(m_align));
`endif
    endtask

    function automatic logic [AW-1:0] rand_wide();
        logic [AW-1:0] r;
        for (int i = 0; i < AW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: check at negedge, drive, then advance the queue model
    task automatic cycle(input logic v, input logic [BW-1:0] w, input logic cn);
        bit pop;
        bit full;
        @(negedge clk);
        check_outputs();
        i_Valid     = v;
        i_SubVector = w;
        i_CntNew    = cn;
        i_Ready     = rand_ready ? 1'($urandom) : ready;
        i_Cnt       = m_pending ? m_pend_w : CW'($urandom);
        @(posedge clk);
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && i_Ready;
        if (pop) m_q.delete(0);
        if (m_pending) begin
            if (full && !pop) m_ovf = 1'b1;
            else              m_q.push_back({i_Cnt, m_pend_v});
        end
        m_pending = v && cn;
        if (v && cn) begin
            m_pend_v = m_next_v;
            m_pend_w = m_next_w;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, BW'($urandom), 1'($urandom));
    endtask

    task automatic send_vector(input logic [VW-1:0] v, input int gap);
        logic [AW-1:0] t;
        t = rand_wide();
        t[VW-1:0] = v;
        cycle(1'b1, t[BW-1:0], 1'b0);
        idle(gap);
        m_next_v  = v;
        m_next_w  = CW'($countones(v));
        m_last_w1 = t[AW-1:BW];
        cycle(1'b1, t[AW-1:BW], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        i_Valid  = 1'b0;
        i_CntNew = 1'b0;
        i_Ready  = 1'b0;
        @(posedge clk);
        m_q.delete();
        m_pending = 1'b0;
        m_ovf     = 1'b0;
`ifdef VEC_PAIR_ALIGN_CHECK_EN
        m_align   = 1'b0;
`endif
        @(negedge clk);
        chk("valid_in_reset", 64'(o_Valid), 64'(0));
        chk("ovf_in_reset", 64'(o_Overflow), 64'(0));
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] w0;
        logic [BW-1:0] w1;
        logic [VW-1:0] exp_v;
        logic [AW-1:0] t;

        n_tests = 0; n_fail = 0;
        rstn = 1'b0; ready = 1'b0; rand_ready = 1'b0;
        i_Valid = 1'b0; i_CntNew = 1'b0; i_Ready = 1'b0;
        i_SubVector = '0; i_Cnt = '0;
        m_ovf = 1'b0; m_pending = 1'b0;
        m_next_v = '0; m_pend_v = '0; m_next_w = '0; m_pend_w = '0; m_last_w1 = '0;
`ifdef VEC_PAIR_ALIGN_CHECK_EN
        m_align = 1'b0;
`endif
        do_reset();

        // Directed A5/5A vector, weight 460, visible two cycles after last word
        w0 = {64{8'hA5}};
        w1 = {64{8'h5A}};
        exp_v = {w1[VW-BW-1:0], w0};
        ready = 1'b0;
        cycle(1'b1, w0, 1'b0);
        m_next_v = exp_v; m_next_w = CW'(460); m_last_w1 = w1;
        cycle(1'b1, w1, 1'b1);
        cycle(1'b0, '0, 1'b0);
        #1;
        chk("lat_valid", 64'(o_Valid), 64'(1));
        chk("lat_weight", 64'(o_Weight), 64'(460));
        chk_vec("lat_vector", o_Vector, exp_v);
        ready = 1'b1;
        idle(3);

        // Eight back-to-back vectors, consumer always ready
        for (int k = 0; k < 8; k++) send_vector(rand_wide()[VW-1:0], 0);
        idle(4);

        // Backpressure: five complete, fifth is dropped
        ready = 1'b0;
        for (int k = 0; k < 5; k++) send_vector(rand_wide()[VW-1:0], 0);
        idle(3);
        #1;
        chk("bp_overflow", 64'(o_Overflow), 64'(1));
        ready = 1'b1;
        idle(6);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) send_vector(rand_wide()[VW-1:0], 0);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        idle(2);
        #1;
        chk("fullpp_no_ovf", 64'(o_Overflow), 64'(0));
        ready = 1'b1;
        idle(6);

        // Random gaps and random ready
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_vector(rand_wide()[VW-1:0], $urandom_range(0, 2));
            idle($urandom_range(0, 1));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(8);

        // Reset after word 0; only the post-reset vector may appear
        t = rand_wide();
        cycle(1'b1, t[BW-1:0], 1'b0);
        do_reset();
        ready = 1'b1;
        send_vector(rand_wide()[VW-1:0], 0);
        idle(4);

`ifdef VEC_PAIR_ALIGN_CHECK_EN
        // Last-word strobe on word 0: error set, pair still pushed
        ready = 1'b0;
        w0 = rand_wide()[BW-1:0];
        m_next_v = {m_last_w1[VW-BW-1:0], w0};
        m_next_w = CW'($urandom);
        cycle(1'b1, w0, 1'b1);
        m_align = 1'b1;
        idle(2);
        #1;
        chk("align_set", 64'(o_AlignErr), 64'(1));
        send_vector(rand_wide()[VW-1:0], 0);
        ready = 1'b1;
        idle(5);
        #1;
        chk("align_sticky", 64'(o_AlignErr), 64'(1));
        do_reset();
        idle(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
